spi_bus_sequencer: RTL and testbench



---
 rtl/spi_bus_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_spi_bus_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_sequencer.sv
// spi_bus_sequencer
//   Turns the SPI byte stream (one command byte plus operand bytes) into
//   single bus transactions for the arbiter. It presents each transaction
//   with a valid/ready handshake, captures read data and drives the
//   Pi-visible completion flag.
//
// Ports
//   clk_sys_i        system clock, rising edge
//   reset_i          synchronous active-high reset
//   spi_cs_ni        frame select (synchronised), high = no frame
//   spi_byte_i       received byte, qualified by spi_byte_valid_i
//   spi_byte_valid_i one-cycle strobe per received byte
//   bus_ready_i      arbiter completion pulse
//   bus_data_i       bus read data, sampled with bus_ready_i
//   bus_addr_o       17-bit transaction address
//   bus_data_o       write data
//   bus_rw_no        1 = read, 0 = write
//   bus_valid_o      transaction pending
//   rd_data_o        last read result
//   spi_ready_o      last command complete, rd_data_o stable
//   overrun_o        pulse when a byte arrives while a transaction is pending
//
// Configuration
//   SPI_BUS_SEQUENCER_FILL_EN  enables opcode 101 (FILL: addr_hi, addr_lo,
//   data, count). Without it, 101 is illegal and the frame is discarded.

module spi_bus_sequencer (
  input  logic        clk_sys_i,
  input  logic        reset_i,
  input  logic        spi_cs_ni,
  input  logic [7:0]  spi_byte_i,
  input  logic        spi_byte_valid_i,
  input  logic        bus_ready_i,
  input  logic [7:0]  bus_data_i,
  output logic [16:0] bus_addr_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_rw_no,
  output logic        bus_valid_o,
  output logic [7:0]  rd_data_o,
  output logic        spi_ready_o,
  output logic        overrun_o
);

  localparam logic [2:0] OP_READ_AT    = 3'b000;
  localparam logic [2:0] OP_READ_NEXT  = 3'b001;
  localparam logic [2:0] OP_WRITE_AT   = 3'b010;
  localparam logic [2:0] OP_WRITE_NEXT = 3'b011;
  localparam logic [2:0] OP_SET_ADDR   = 3'b100;
`ifdef SPI_BUS_SEQUENCER_FILL_EN
  localparam logic [2:0] OP_FILL       = 3'b101;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_HI = 3'd1,
    S_ADDR_LO = 3'd2,
    S_DATA    = 3'd3,
    S_COUNT   = 3'd4,
    S_ISSUE   = 3'd5,
    S_DISCARD = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [8:0]  hi_q, hi_d;         // {cmd[0], addr_hi}
  logic [7:0]  lo_q, lo_d;
  // addr_q is the internal address register and also drives bus_addr_o;
  // it only changes when a transaction is issued or SET_ADDR completes.
  logic [16:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        rw_q, rw_d;
  logic        valid_q, valid_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        ready_q, ready_d;
  logic        overrun_q, overrun_d;
`ifdef SPI_BUS_SEQUENCER_FILL_EN
  logic [8:0]  remain_q, remain_d; // writes left including the one in flight
  logic        stop_q, stop_d;     // frame ended during fill
`endif

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rw_d      = rw_q;
    valid_d   = valid_q;
    rd_data_d = rd_data_q;
    ready_d   = ready_q;
    overrun_d = 1'b0;
`ifdef SPI_BUS_SEQUENCER_FILL_EN
    remain_d  = remain_q;
    stop_d    = stop_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (spi_byte_valid_i && !spi_cs_ni) begin
          op_d    = spi_byte_i[7:5];
          hi_d[8] = spi_byte_i[0];
          case (spi_byte_i[7:5])
            OP_READ_AT, OP_WRITE_AT, OP_SET_ADDR: begin
              state_d = S_ADDR_HI;
              ready_d = 1'b0;
            end
            OP_READ_NEXT: begin
              addr_d  = addr_q + 17'd1;
              rw_d    = 1'b1;
              valid_d = 1'b1;
              ready_d = 1'b0;
              state_d = S_ISSUE;
            end
            OP_WRITE_NEXT: begin
              state_d = S_DATA;
              ready_d = 1'b0;
            end
`ifdef SPI_BUS_SEQUENCER_FILL_EN
            OP_FILL: begin
              state_d = S_ADDR_HI;
              ready_d = 1'b0;
            end
`endif
            default: state_d = S_DISCARD;  // illegal: ready stays high
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ADDR_HI: begin
        if (spi_cs_ni) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else if (spi_byte_valid_i) begin
          hi_d[7:0] = spi_byte_i;
          state_d   = S_ADDR_LO;
        end else begin
          state_d = S_ADDR_HI;
        end
      end

      S_ADDR_LO: begin
        if (spi_cs_ni) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else if (spi_byte_valid_i) begin
          lo_d = spi_byte_i;
          case (op_q)
            OP_SET_ADDR: begin
              addr_d  = {hi_q, spi_byte_i};
              ready_d = 1'b1;
              state_d = S_IDLE;
            end
            OP_READ_AT: begin
              addr_d  = {hi_q, spi_byte_i};
              rw_d    = 1'b1;
              valid_d = 1'b1;
              state_d = S_ISSUE;
            end
            default: state_d = S_DATA;     // WRITE_AT and FILL
          endcase
        end else begin
          state_d = S_ADDR_LO;
        end
      end

      S_DATA: begin
        if (spi_cs_ni) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else if (spi_byte_valid_i) begin
          data_d = spi_byte_i;
          if (op_q == OP_WRITE_NEXT) begin
            addr_d  = addr_q + 17'd1;
            rw_d    = 1'b0;
            valid_d = 1'b1;
            state_d = S_ISSUE;
`ifdef SPI_BUS_SEQUENCER_FILL_EN
          end else if (op_q == OP_FILL) begin
            state_d = S_COUNT;
`endif
          end else begin
            addr_d  = {hi_q, lo_q};
            rw_d    = 1'b0;
            valid_d = 1'b1;
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_DATA;
        end
      end

      S_COUNT: begin
`ifdef SPI_BUS_SEQUENCER_FILL_EN
        if (spi_cs_ni) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else if (spi_byte_valid_i) begin
          remain_d = (spi_byte_i == 8'd0) ? 9'd256 : {1'b0, spi_byte_i};
          stop_d   = 1'b0;
          addr_d   = {hi_q, lo_q};
          rw_d     = 1'b0;
          valid_d  = 1'b1;
          state_d  = S_ISSUE;
        end else begin
          state_d = S_COUNT;
        end
`else
        state_d = S_IDLE;
        ready_d = 1'b1;
`endif
      end

      S_ISSUE: begin
        overrun_d = spi_byte_valid_i;
`ifdef SPI_BUS_SEQUENCER_FILL_EN
        if (spi_cs_ni) begin
          stop_d = 1'b1;
        end else begin
          stop_d = stop_q;
        end
`endif
        if (bus_ready_i) begin
`ifdef SPI_BUS_SEQUENCER_FILL_EN
          // Fill keeps valid high and steps to the next address.
          if (op_q == OP_FILL && remain_q != 9'd1 && !stop_q && !spi_cs_ni) begin
            addr_d   = addr_q + 17'd1;
            remain_d = remain_q - 9'd1;
          end else begin
            valid_d = 1'b0;
            ready_d = 1'b1;
            state_d = S_IDLE;
          end
`else
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
`endif
          if (rw_q) begin
            rd_data_d = bus_data_i;
          end else begin
            rd_data_d = rd_data_q;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end

      S_DISCARD: begin
        if (spi_cs_ni) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DISCARD;
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      op_q      <= 3'd0;
      hi_q      <= 9'd0;
      lo_q      <= 8'd0;
      addr_q    <= 17'd0;
      data_q    <= 8'd0;
      rw_q      <= 1'b1;
      valid_q   <= 1'b0;
      rd_data_q <= 8'd0;
      ready_q   <= 1'b1;
      overrun_q <= 1'b0;
`ifdef SPI_BUS_SEQUENCER_FILL_EN
      remain_q  <= 9'd0;
      stop_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rw_q      <= rw_d;
      valid_q   <= valid_d;
      rd_data_q <= rd_data_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
`ifdef SPI_BUS_SEQUENCER_FILL_EN
      remain_q  <= remain_d;
      stop_q    <= stop_d;
`endif
    end
  end

  assign bus_addr_o  = addr_q;
  assign bus_data_o  = data_q;
  assign bus_rw_no   = rw_q;
  assign bus_valid_o = valid_q;
  assign rd_data_o   = rd_data_q;
  assign spi_ready_o = ready_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_spi_bus_sequencer.sv
// Directed bench for spi_bus_sequencer. Inputs change 1 time unit after a
// rising edge and outputs are checked at the same point.
module tb_spi_bus_sequencer;

  logic        clk_sys_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        spi_cs_ni = 1'b1;
  logic [7:0]  spi_byte_i = 8'h00;
  logic        spi_byte_valid_i = 1'b0;
  logic        bus_ready_i = 1'b0;
  logic [7:0]  bus_data_i = 8'h00;
  logic [16:0] bus_addr_o;
  logic [7:0]  bus_data_o;
  logic        bus_rw_no;
  logic        bus_valid_o;
  logic [7:0]  rd_data_o;
  logic        spi_ready_o;
  logic        overrun_o;

  int vectors = 0;
  int errors  = 0;

  spi_bus_sequencer dut (
    .clk_sys_i(clk_sys_i), .reset_i(reset_i), .spi_cs_ni(spi_cs_ni),
    .spi_byte_i(spi_byte_i), .spi_byte_valid_i(spi_byte_valid_i),
    .bus_ready_i(bus_ready_i), .bus_data_i(bus_data_i),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_rw_no(bus_rw_no),
    .bus_valid_o(bus_valid_o), .rd_data_o(rd_data_o),
    .spi_ready_o(spi_ready_o), .overrun_o(overrun_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  task automatic tick();
    @(posedge clk_sys_i);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    spi_byte_i       = b;
    spi_byte_valid_i = 1'b1;
    tick();
    spi_byte_valid_i = 1'b0;
  endtask

  task automatic pulse_ready(input logic [7:0] d);
    bus_ready_i = 1'b1;
    bus_data_i  = d;
    tick();
    bus_ready_i = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    tick(); tick();
    reset_i = 1'b0;
    check("rst_valid", bus_valid_o, 0);
    check("rst_ready", spi_ready_o, 1);
    check("rst_rw", bus_rw_no, 1);
    check("rst_addr", bus_addr_o, 0);
    check("rst_data", bus_data_o, 0);
    check("rst_rd", rd_data_o, 0);
    check("rst_ovr", overrun_o, 0);

    // WRITE_AT 41 80 00 55
    spi_cs_ni = 1'b0;
    send(8'h41);
    check("wa_ready_drop", spi_ready_o, 0);
    send(8'h80); send(8'h00);
    check("wa_no_valid_yet", bus_valid_o, 0);
    send(8'h55);
    check("wa_valid", bus_valid_o, 1);
    check("wa_addr", bus_addr_o, 32'h18000);
    check("wa_data", bus_data_o, 32'h55);
    check("wa_rw", bus_rw_no, 0);
    tick(); tick(); tick();
    check("wa_hold_valid", bus_valid_o, 1);
    check("wa_hold_addr", bus_addr_o, 32'h18000);
    check("wa_hold_ready", spi_ready_o, 0);
    pulse_ready(8'hEE);
    check("wa_done_valid", bus_valid_o, 0);
    check("wa_done_ready", spi_ready_o, 1);
    check("wa_rd_unchanged", rd_data_o, 0);
    spi_cs_ni = 1'b1; tick();

    // SET_ADDR 81 FF FF then READ_NEXT 20 (wrap)
    spi_cs_ni = 1'b0;
    send(8'h81);
    check("sa_ready_drop", spi_ready_o, 0);
    send(8'hFF); send(8'hFF);
    check("sa_ready", spi_ready_o, 1);
    check("sa_valid", bus_valid_o, 0);
    check("sa_addr", bus_addr_o, 32'h1FFFF);
    send(8'h20);
    check("rn_valid", bus_valid_o, 1);
    check("rn_addr_wrap", bus_addr_o, 0);
    check("rn_rw", bus_rw_no, 1);
    check("rn_ready", spi_ready_o, 0);
    tick();
    pulse_ready(8'hA5);
    check("rn_rd", rd_data_o, 32'hA5);
    check("rn_valid_off", bus_valid_o, 0);
    check("rn_ready_on", spi_ready_o, 1);
    spi_cs_ni = 1'b1; tick();

    // READ_AT aborted by end of frame
    spi_cs_ni = 1'b0;
    send(8'h00);
    check("ab_ready_drop", spi_ready_o, 0);
    send(8'h12);
    spi_cs_ni = 1'b1; tick();
    check("ab_ready", spi_ready_o, 1);
    check("ab_valid", bus_valid_o, 0);
    check("ab_addr_kept", bus_addr_o, 0);
    tick();
    spi_cs_ni = 1'b0;
    send(8'h20);
    check("ab_next_valid", bus_valid_o, 1);
    check("ab_next_addr", bus_addr_o, 1);
    pulse_ready(8'h3C);
    check("ab_next_rd", rd_data_o, 32'h3C);
    spi_cs_ni = 1'b1; tick();

    // WRITE_NEXT with an overrun byte
    spi_cs_ni = 1'b0;
    send(8'h60); send(8'h77);
    check("wn_valid", bus_valid_o, 1);
    check("wn_addr", bus_addr_o, 2);
    check("wn_data", bus_data_o, 32'h77);
    check("wn_rw", bus_rw_no, 0);
    send(8'h99);
    check("wn_ovr_pulse", overrun_o, 1);
    tick();
    check("wn_ovr_clear", overrun_o, 0);
    check("wn_still_valid", bus_valid_o, 1);
    check("wn_data_kept", bus_data_o, 32'h77);
    check("wn_addr_kept", bus_addr_o, 2);
    pulse_ready(8'h00);
    check("wn_done_valid", bus_valid_o, 0);
    check("wn_done_ready", spi_ready_o, 1);
    check("wn_rd_kept", rd_data_o, 32'h3C);
    spi_cs_ni = 1'b1; tick();

    // Stray ready while idle is ignored
    pulse_ready(8'hFF);
    check("idle_rdy_rd", rd_data_o, 32'h3C);
    check("idle_rdy_valid", bus_valid_o, 0);

    // Illegal opcode E0: discard until frame end
    spi_cs_ni = 1'b0;
    send(8'hE0);
    check("il_ready", spi_ready_o, 1);
    check("il_valid", bus_valid_o, 0);
    send(8'h20);
    check("il_ignored_valid", bus_valid_o, 0);
    check("il_ignored_ready", spi_ready_o, 1);
    check("il_addr", bus_addr_o, 2);
    spi_cs_ni = 1'b1; tick();
    spi_cs_ni = 1'b0;
    send(8'h20);
    check("il_after_valid", bus_valid_o, 1);
    check("il_after_addr", bus_addr_o, 3);
    pulse_ready(8'h11);
    check("il_after_rd", rd_data_o, 32'h11);
    spi_cs_ni = 1'b1; tick();

`ifdef SPI_BUS_SEQUENCER_FILL_EN
    // FILL A0 10 00 00 03
    spi_cs_ni = 1'b0;
    send(8'hA0);
    check("fl_ready_drop", spi_ready_o, 0);
    send(8'h10); send(8'h00); send(8'h00); send(8'h03);
    check("fl_valid0", bus_valid_o, 1);
    check("fl_addr0", bus_addr_o, 32'h01000);
    check("fl_data", bus_data_o, 0);
    check("fl_rw", bus_rw_no, 0);
    tick();
    pulse_ready(8'h00);
    check("fl_valid1", bus_valid_o, 1);
    check("fl_addr1", bus_addr_o, 32'h01001);
    check("fl_ready1", spi_ready_o, 0);
    pulse_ready(8'h00);
    check("fl_addr2", bus_addr_o, 32'h01002);
    check("fl_ready2", spi_ready_o, 0);
    pulse_ready(8'h00);
    check("fl_valid_end", bus_valid_o, 0);
    check("fl_ready_end", spi_ready_o, 1);
    check("fl_addr_end", bus_addr_o, 32'h01002);
    spi_cs_ni = 1'b1; tick();
`else
    // 101 is illegal without the fill option
    spi_cs_ni = 1'b0;
    send(8'hA0);
    check("fl_off_ready", spi_ready_o, 1);
    send(8'h10); send(8'h00); send(8'h00); send(8'h03);
    check("fl_off_valid", bus_valid_o, 0);
    check("fl_off_addr", bus_addr_o, 3);
    spi_cs_ni = 1'b1; tick();
`endif

    // Reset during ISSUE
    spi_cs_ni = 1'b0;
    send(8'h20);
    check("ri_valid", bus_valid_o, 1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("ri_valid_off", bus_valid_o, 0);
    check("ri_ready", spi_ready_o, 1);
    check("ri_rw", bus_rw_no, 1);
    check("ri_addr", bus_addr_o, 0);
    check("ri_rd", rd_data_o, 0);
    spi_cs_ni = 1'b1; tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
